// File: rtl/timer_countdown.sv
// timer_countdown
//   Three-digit BCD cook timer (M:ST:SU). In entry mode, digits shift in from
//   the keypad encoder on each falling edge of loadn. In run mode the timer
//   counts down once per rising edge of pgt_1hz, stops at 0:00 and pulses done.
//
// Ports
//   clk      in   system clock, all state on rising edge
//   clearn   in   asynchronous active-low reset
//   data_in  in   [3:0] BCD digit from encoder
//   loadn    in   active-low load strobe (may be held low)
//   pgt_1hz  in   1 Hz tick level, sampled on clk
//   startn   in   active-low run request (high = entry / pause)
//   mins     out  [3:0] minutes digit
//   sec_tens out  [3:0] tens-of-seconds digit
//   sec_ones out  [3:0] units-of-seconds digit
//   zero     out  all digits are 0 (combinational)
//   running  out  high while counting
//   done     out  one-clock pulse when counting reaches 0:00
module timer_countdown #(
  parameter logic [3:0] SEC_TENS_RELOAD = 4'd5,
  parameter logic [3:0] SEC_ONES_RELOAD = 4'd9
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] data_in,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {ENTRY, RUN, DONE} state_t;

  state_t state;
  logic   loadn_q;
  logic   pgt_q;
  logic   load_ev;
  logic   tick_ev;
  logic   last_tick;

  always_comb begin
    load_ev   = loadn_q & ~loadn;
    tick_ev   = ~pgt_q & pgt_1hz;
    zero      = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    // The decrement in flight lands on 0:00.
    last_tick = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= ENTRY;
      mins     <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      loadn_q  <= 1'b1;
      pgt_q    <= 1'b0;
    end else begin
      loadn_q <= loadn;
      pgt_q   <= pgt_1hz;
      done    <= 1'b0;
      case (state)
        ENTRY: begin
          if (load_ev && (data_in <= 4'd9)) begin
            mins     <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= data_in;
          end
          if (!startn && !zero) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          // Pause wins over a coincident tick: digits are held untouched.
          if (startn) begin
            state   <= ENTRY;
            running <= 1'b0;
          end else if (tick_ev) begin
            if (sec_ones != 4'd0) begin
              sec_ones <= sec_ones - 4'd1;
            end else begin
              sec_ones <= SEC_ONES_RELOAD;
              if (sec_tens != 4'd0) begin
                sec_tens <= sec_tens - 4'd1;
              end else begin
                sec_tens <= SEC_TENS_RELOAD;
                mins     <= mins - 4'd1;
              end
            end
            if (last_tick) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        DONE: begin
          if (startn) state <= ENTRY;
        end
        default: begin
          state   <= ENTRY;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_countdown.sv
// tb_timer_countdown
//   Directed bench for timer_countdown. Expected outputs are queued as each
//   stimulus step is applied and drained against the DUT at the sample point
//   (negative clock edge, away from the active edge).
module tb_timer_countdown;

  logic       clk;
  logic       clearn;
  logic [3:0] data_in;
  logic       loadn;
  logic       pgt_1hz;
  logic       startn;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       zero;
  logic       running;
  logic       done;

  int n_run  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  typedef struct {
    string      tag;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       z;
    logic       r;
    logic       d;
  } exp_t;

  exp_t sb[$];

  timer_countdown #(
    .SEC_TENS_RELOAD(4'd5),
    .SEC_ONES_RELOAD(4'd9)
  ) dut (
    .clk      (clk),
    .clearn   (clearn),
    .data_in  (data_in),
    .loadn    (loadn),
    .pgt_1hz  (pgt_1hz),
    .startn   (startn),
    .mins     (mins),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .zero     (zero),
    .running  (running),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of sampled cycles in which done was seen high.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic expect_out(input string tag, input int m, input int t, input int o,
                            input logic r, input logic d);
    exp_t e;
    e.tag = tag;
    e.m   = 4'(m);
    e.t   = 4'(t);
    e.o   = 4'(o);
    e.z   = (m == 0) && (t == 0) && (o == 0);
    e.r   = r;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_run++;
      assert ({mins, sec_tens, sec_ones, zero, running, done} ===
              {e.m, e.t, e.o, e.z, e.r, e.d})
      else begin
        n_fail++;
        $error("FAIL %s: got %0d:%0d%0d zero=%b running=%b done=%b, expected %0d:%0d%0d zero=%b running=%b done=%b",
               e.tag, mins, sec_tens, sec_ones, zero, running, done,
               e.m, e.t, e.o, e.z, e.r, e.d);
      end
    end
  endtask

  task automatic check_done_cnt(input string tag, input int expv);
    n_run++;
    assert (done_cnt === expv)
    else begin
      n_fail++;
      $error("FAIL %s: done pulses got %0d, expected %0d", tag, done_cnt, expv);
    end
  endtask

  // Key press: loadn held low for 5 clocks, then released.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    data_in = d;
    loadn   = 1'b0;
    repeat (5) @(negedge clk);
    loadn = 1'b1;
    @(negedge clk);
  endtask

  // pgt_1hz held high for 3 clocks: exactly one decrement, done only on the first sample.
  task automatic tick(input string tag, input int m, input int t, input int o,
                      input logic r, input logic d);
    @(negedge clk);
    pgt_1hz = 1'b1;
    @(negedge clk);
    expect_out(tag, m, t, o, r, d);
    check_sb();
    repeat (2) @(negedge clk);
    expect_out({tag, "_hold"}, m, t, o, r, 1'b0);
    check_sb();
    pgt_1hz = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_start(input logic s);
    @(negedge clk);
    startn = s;
    @(negedge clk);
  endtask

  initial begin
    clearn  = 1'b0;
    data_in = 4'd0;
    loadn   = 1'b1;
    pgt_1hz = 1'b0;
    startn  = 1'b1;

    // T1 reset
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0, 1'b0, 1'b0);
    check_sb();
    clearn = 1'b1;
    @(negedge clk);
    expect_out("reset_release", 0, 0, 0, 1'b0, 1'b0);
    check_sb();

    // T2 entry
    press(4'd1); expect_out("key1", 0, 0, 1, 1'b0, 1'b0); check_sb();
    press(4'd3); expect_out("key3", 0, 1, 3, 1'b0, 1'b0); check_sb();
    press(4'd0); expect_out("key0", 1, 3, 0, 1'b0, 1'b0); check_sb();
    press(4'hB); expect_out("key_invalid", 1, 3, 0, 1'b0, 1'b0); check_sb();

    // T3 count
    set_start(1'b0);
    expect_out("start_130", 1, 3, 0, 1'b1, 1'b0); check_sb();
    tick("tick_129", 1, 2, 9, 1'b1, 1'b0);
    tick("tick_128", 1, 2, 8, 1'b1, 1'b0);
    tick("tick_127", 1, 2, 7, 1'b1, 1'b0);
    set_start(1'b1);
    expect_out("pause_127", 1, 2, 7, 1'b0, 1'b0); check_sb();
    press(4'd1); press(4'd0); press(4'd0);
    expect_out("entry_100", 1, 0, 0, 1'b0, 1'b0); check_sb();
    set_start(1'b0);
    tick("borrow_059", 0, 5, 9, 1'b1, 1'b0);

    // T4 finish
    set_start(1'b1);
    press(4'd0); press(4'd0); press(4'd2);
    expect_out("entry_002", 0, 0, 2, 1'b0, 1'b0); check_sb();
    set_start(1'b0);
    tick("tick_001", 0, 0, 1, 1'b1, 1'b0);
    tick("tick_000", 0, 0, 0, 1'b0, 1'b1);
    tick("done_hold", 0, 0, 0, 1'b0, 1'b0);
    check_done_cnt("done_once", 1);
    set_start(1'b1);

    // T5 corners: start at 0:00 stays in entry
    set_start(1'b0);
    @(negedge clk);
    expect_out("start_at_zero", 0, 0, 0, 1'b0, 1'b0); check_sb();
    set_start(1'b1);
    press(4'd7); press(4'd5);
    expect_out("entry_075", 0, 7, 5, 1'b0, 1'b0); check_sb();
    set_start(1'b0);
    tick("tick_074", 0, 7, 4, 1'b1, 1'b0);
    // Pause and tick on the same clock
    @(negedge clk);
    startn  = 1'b1;
    pgt_1hz = 1'b1;
    @(negedge clk);
    expect_out("pause_vs_tick", 0, 7, 4, 1'b0, 1'b0); check_sb();
    pgt_1hz = 1'b0;
    set_start(1'b0);
    expect_out("resume_074", 0, 7, 4, 1'b1, 1'b0); check_sb();
    press(4'd3);
    expect_out("load_in_run", 0, 7, 4, 1'b1, 1'b0); check_sb();
    for (int v = 73; v >= 69; v--) tick("count_7x", 0, v / 10, v % 10, 1'b1, 1'b0);

    // T6 async reset during RUN at 0:45
    set_start(1'b1);
    press(4'd0); press(4'd4); press(4'd5);
    expect_out("entry_045", 0, 4, 5, 1'b0, 1'b0); check_sb();
    set_start(1'b0);
    expect_out("run_045", 0, 4, 5, 1'b1, 1'b0); check_sb();
    @(posedge clk);
    #2 clearn = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 1'b0, 1'b0); check_sb();
    repeat (2) @(negedge clk);
    clearn = 1'b1;
    startn = 1'b1;
    repeat (2) @(negedge clk);
    expect_out("after_reset", 0, 0, 0, 1'b0, 1'b0); check_sb();
    check_done_cnt("no_done_on_reset", 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
